// File: rtl/ms_rr_arbiter.sv
// rtl/ms_rr_arbiter.sv - round-robin arbiter sharing one blocking slave port among masters
module ms_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          m_sync,
    input  logic [NUM_REQ*DATA_W-1:0]   m_data,
    output logic [NUM_REQ-1:0]          m_notify,
    output logic [NUM_REQ-1:0]          m_err,
    output logic                        s_notify,
    output logic [DATA_W-1:0]           s_data,
    input  logic                        s_sync,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        busy
);

    // Timer only needs to count 0..TIMEOUT-1; with TIMEOUT=0 it stays parked at 0.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [DATA_W-1:0]      s_data_q, s_data_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]     m_notify_q, m_notify_d;
    logic [NUM_REQ-1:0]     m_err_q, m_err_d;

    logic [NUM_REQ-1:0]     eligible;
    logic [2*NUM_REQ-1:0]   rotated;
    logic                   found;
    logic [IDX_W-1:0]       winner;
    logic [DATA_W-1:0]      win_data;
    logic [IDX_W-1:0]       next_ptr;

    // A master that is being pulsed this cycle still holds its sync, so it is masked out.
    assign eligible = m_sync & ~(m_notify_q | m_err_q);

    // Rotating the doubled request vector puts rr_ptr at bit 0, so the first set bit wins.
    assign rotated  = {eligible, eligible} >> rr_ptr_q;

    // The served master drops to lowest priority by moving the pointer just past it.
    assign next_ptr = (grant_q == IDX_LAST) ? '0 : grant_q + IDX_W'(1);

    // Round-robin search for the winner and selection of its payload slice.
    always_comb begin
        int wsum;
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        wsum     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                wsum  = int'(rr_ptr_q) + k;
                if (wsum >= NUM_REQ) begin
                    wsum = wsum - NUM_REQ;
                end
                winner = IDX_W'(wsum);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == IDX_W'(j)) begin
                win_data = m_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic: grant in IDLE, wait for accept or timeout in OFFER.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        timer_d    = timer_q;
        s_data_d   = s_data_q;
        grant_d    = grant_q;
        m_notify_d = '0;
        m_err_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    s_data_d = win_data;
                    grant_d  = winner;
                    timer_d  = '0;
                    state_d  = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (s_sync) begin
                    m_notify_d[grant_q] = 1'b1;
                    rr_ptr_d            = next_ptr;
                    state_d             = ST_IDLE;
                end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
                    m_err_d[grant_q] = 1'b1;
                    rr_ptr_d         = next_ptr;
                    state_d          = ST_IDLE;
                end else if (timer_q != TMR_LAST) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            timer_q    <= '0;
            s_data_q   <= '0;
            grant_q    <= '0;
            m_notify_q <= '0;
            m_err_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            timer_q    <= timer_d;
            s_data_q   <= s_data_d;
            grant_q    <= grant_d;
            m_notify_q <= m_notify_d;
            m_err_q    <= m_err_d;
        end
    end

    assign s_notify = (state_q == ST_OFFER);
    assign busy     = (state_q == ST_OFFER);
    assign s_data   = s_data_q;
    assign grant_id = grant_q;
    assign m_notify = m_notify_q;
    assign m_err    = m_err_q;

endmodule

// File: tb/tb_ms_rr_arbiter.sv
// tb/tb_ms_rr_arbiter.sv - self-checking bench for ms_rr_arbiter
module tb_ms_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   m_sync;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]   m_notify, m_err;
    logic           s_notify;
    logic [DW-1:0]  s_data;
    logic           s_sync;
    logic [1:0]     grant_id;
    logic           busy;

    logic [N-1:0]   m_sync_z;
    logic [N-1:0]   m_notify_z, m_err_z;
    logic           s_notify_z;
    logic [DW-1:0]  s_data_z;
    logic           s_sync_z;
    logic [1:0]     grant_id_z;
    logic           busy_z;

    always #5 clk = ~clk;

    ms_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .m_sync(m_sync), .m_data(m_data),
        .m_notify(m_notify), .m_err(m_err), .s_notify(s_notify), .s_data(s_data),
        .s_sync(s_sync), .grant_id(grant_id), .busy(busy)
    );

    ms_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(0)) dut_z (
        .clk(clk), .rst(rst), .m_sync(m_sync_z), .m_data(m_data),
        .m_notify(m_notify_z), .m_err(m_err_z), .s_notify(s_notify_z), .s_data(s_data_z),
        .s_sync(s_sync_z), .grant_id(grant_id_z), .busy(busy_z)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  sync;
        logic        ss;
        logic        sn;
        logic [1:0]  gid;
        logic [31:0] sd;
        logic [3:0]  mn;
        logic [3:0]  me;
    } vec_t;

    vec_t vt[21];

    // reference model state
    bit          mo_act;
    int          mo_gid, mo_ptr, mo_start;
    logic [31:0] mo_data;
    logic [3:0]  mo_mn, mo_me;
    logic [3:0]  req;
    logic [31:0] md[4];
    bit          drop[4];

    initial begin
        int n;
        int stuck;
        logic [3:0] elig, nmn, nme;
        int w;

        vt[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h00, 4'b0000, 4'b0000};
        vt[1]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 32'h11, 4'b0000, 4'b0000};
        vt[2]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 32'h11, 4'b0001, 4'b0000};
        vt[3]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 32'h22, 4'b0000, 4'b0000};
        vt[4]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd1, 32'h22, 4'b0010, 4'b0000};
        vt[5]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 32'hA5, 4'b0000, 4'b0000};
        vt[6]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd2, 32'hA5, 4'b0100, 4'b0000};
        vt[7]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd3, 32'h44, 4'b0000, 4'b0000};
        vt[8]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd3, 32'h44, 4'b1000, 4'b0000};
        vt[9]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 32'h11, 4'b0000, 4'b0000};
        vt[10] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 32'h11, 4'b0001, 4'b0000};
        vt[11] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h11, 4'b0000, 4'b0000};
        vt[12] = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 32'hA5, 4'b0000, 4'b0000};
        vt[13] = '{1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 32'hA5, 4'b0100, 4'b0000};
        vt[14] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 32'hA5, 4'b0000, 4'b0000};
        vt[15] = '{1'b0, 4'b0110, 1'b0, 1'b1, 2'd1, 32'h22, 4'b0000, 4'b0000};
        vt[16] = '{1'b0, 4'b0010, 1'b1, 1'b0, 2'd1, 32'h22, 4'b0010, 4'b0000};
        vt[17] = '{1'b0, 4'b0010, 1'b0, 1'b0, 2'd1, 32'h22, 4'b0000, 4'b0000};
        vt[18] = '{1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 32'h22, 4'b0000, 4'b0000};
        vt[19] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 32'h22, 4'b0010, 4'b0000};
        vt[20] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 32'h22, 4'b0000, 4'b0000};

        rst      = 1'b1;
        m_sync   = '0;
        s_sync   = 1'b0;
        m_sync_z = '0;
        s_sync_z = 1'b0;
        m_data   = {32'h44, 32'hA5, 32'h22, 32'h11};

        // directed vectors: reset, round robin, single request, mask
        for (int i = 0; i < 21; i++) begin
            rst    = vt[i].rst;
            m_sync = vt[i].sync;
            s_sync = vt[i].ss;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  {s_notify, busy, grant_id, s_data, m_notify, m_err},
                  {vt[i].sn, vt[i].sn, vt[i].gid, vt[i].sd, vt[i].mn, vt[i].me});
            if (i == 0) begin
                check("rst_z", {s_notify_z, busy_z, grant_id_z, s_data_z, m_notify_z, m_err_z}, 64'd0);
            end
        end

        // timeout: master 0 stalls, master 2 waits behind it
        m_sync = 4'b0001;
        s_sync = 1'b0;
        @(posedge clk); #1;
        check("to_rise", {s_notify, grant_id}, {1'b1, 2'd0});
        m_sync = 4'b0101;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (m_err != 0 || m_notify != 0 || !s_notify) break;
        end
        check("to_cycles", n, 15);
        check("to_err", {m_err, m_notify, s_notify}, {4'b0001, 4'b0000, 1'b0});
        @(posedge clk); #1;
        check("to_next", {s_notify, grant_id, s_data}, {1'b1, 2'd2, 32'hA5});
        m_sync = 4'b0100;
        s_sync = 1'b1;
        @(posedge clk); #1;
        check("to_next_done", {m_notify, m_err}, {4'b0100, 4'b0000});
        m_sync = 4'b0000;
        s_sync = 1'b0;
        @(posedge clk); #1;

        // reset while offering with slave accepting
        m_sync = 4'b0100;
        @(posedge clk); #1;
        check("rst_pre", {s_notify, grant_id}, {1'b1, 2'd2});
        rst    = 1'b1;
        s_sync = 1'b1;
        m_sync = 4'b0000;
        @(posedge clk); #1;
        check("rst_outs", {s_notify, busy, grant_id, s_data, m_notify, m_err}, 64'd0);
        rst    = 1'b0;
        s_sync = 1'b0;
        m_sync = 4'b1010;
        @(posedge clk); #1;
        check("rst_first", {s_notify, grant_id, s_data, m_notify}, {1'b1, 2'd1, 32'h22, 4'b0000});
        s_sync = 1'b1;
        @(posedge clk); #1;
        check("rst_done", m_notify, 4'b0010);
        m_sync = 4'b0000;
        s_sync = 1'b0;
        @(posedge clk); #1;

        // TIMEOUT=0 instance never aborts
        m_sync_z = 4'b0001;
        @(posedge clk); #1;
        check("to0_rise", {s_notify_z, grant_id_z, s_data_z}, {1'b1, 2'd0, 32'h11});
        stuck = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (!s_notify_z || m_err_z != 0 || m_notify_z != 0) stuck++;
        end
        check("to0_hold", stuck, 0);
        s_sync_z = 1'b1;
        @(posedge clk); #1;
        check("to0_accept", {m_notify_z, m_err_z, s_notify_z}, {4'b0001, 4'b0000, 1'b0});
        m_sync_z = 4'b0000;
        s_sync_z = 1'b0;

        // randomized traffic against the reference model
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        mo_act   = 0;
        mo_gid   = 0;
        mo_ptr   = 0;
        mo_start = 0;
        mo_data  = '0;
        mo_mn    = '0;
        mo_me    = '0;
        req      = '0;
        for (int i = 0; i < 4; i++) begin
            md[i]   = '0;
            drop[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (drop[i]) begin
                    req[i]  = 1'b0;
                    drop[i] = 0;
                end else if (mo_mn[i] || mo_me[i]) begin
                    drop[i] = 1;
                end else if (!req[i] && $urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                    md[i]  = $urandom;
                end
            end
            m_sync = req;
            m_data = {md[3], md[2], md[1], md[0]};
            s_sync = ($urandom_range(7) == 0);

            nmn = '0;
            nme = '0;
            if (mo_act) begin
                if (s_sync) begin
                    nmn[mo_gid] = 1'b1;
                    mo_act = 0;
                    mo_ptr = (mo_gid + 1) % N;
                end else if (c - mo_start == TO - 1) begin
                    nme[mo_gid] = 1'b1;
                    mo_act = 0;
                    mo_ptr = (mo_gid + 1) % N;
                end
            end else begin
                elig = req & ~(mo_mn | mo_me);
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && elig[(mo_ptr + k) % N]) w = (mo_ptr + k) % N;
                end
                if (w >= 0) begin
                    mo_act   = 1;
                    mo_gid   = w;
                    mo_data  = md[w];
                    mo_start = c + 1;
                end
            end
            mo_mn = nmn;
            mo_me = nme;

            @(posedge clk); #1;
            check($sformatf("rand%0d", c),
                  {s_notify, busy, grant_id, s_data, m_notify, m_err},
                  {mo_act, mo_act, 2'(mo_gid), mo_data, mo_mn, mo_me});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
